// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the arithmetic instruction format (mode/opcode/regA/regB).
// Imported by the issue queue, the control unit and the ALU.
package cpu_isa_pkg;

  localparam int unsigned ISA_W    = 8;
  localparam int unsigned MODE_BIT = 7;
  localparam int unsigned OPC_HI   = 6;
  localparam int unsigned OPC_LO   = 4;
  localparam int unsigned RA_HI    = 3;
  localparam int unsigned RA_LO    = 2;
  localparam int unsigned RB_HI    = 1;
  localparam int unsigned RB_LO    = 0;

  localparam logic [2:0] OPC_ADD = 3'b001;
  localparam logic [2:0] OPC_INC = 3'b011;

  typedef enum logic {
    S_IDLE,
    S_PRESENT
  } issue_state_e;

  function automatic logic is_legal_arith(input logic [ISA_W-1:0] w);
    logic [2:0] opc;
    opc = w[OPC_HI:OPC_LO];
    return !w[MODE_BIT] && ((opc == OPC_ADD) || (opc == OPC_INC));
  endfunction

endpackage

// File: rtl/instr_ring.sv
// DEPTH x W circular instruction store with head/tail/count bookkeeping.
// Callers guarantee push only when not full and pop only when not empty.
module instr_ring #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [W-1:0]               push_data_i,
  input  logic                       pop_i,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx_i,
  output logic [W-1:0]               rd_data_o,
  output logic [$clog2(DEPTH)-1:0]   head_o,
  output logic [$clog2(DEPTH)-1:0]   tail_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [AW:0]   count_q;

  always_ff @(posedge clock) begin
    if (push_i) mem_q[tail_q] <= push_data_i;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) tail_q <= tail_q + 1'b1;
      if (pop_i)  head_q <= head_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];
  assign head_o    = head_q;
  assign tail_o    = tail_q;
  assign count_o   = count_q;
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);

endmodule

// File: rtl/instr_issue_queue.sv
// Instruction writer side of the fetch interface: filters illegal words on write,
// buffers them in instr_ring and issues them over valid/ready, optionally replaying in loop mode.
module instr_issue_queue
  import cpu_isa_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IW    = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [IW-1:0]            wr_instr,
  output logic                     wr_full,
  output logic                     wr_reject,
  input  logic                     run,
  input  logic                     loop,
  input  logic                     rd_ready,
  output logic                     instr_valid,
  output logic [IW-1:0]            instr_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     err_sticky,
  input  logic                     clr_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  issue_state_e  state_q, state_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [AW-1:0] iptr_q, iptr_d;
  logic          loop_q, loop_d;
  logic          reject_q, err_q;

  logic [AW-1:0] head, tail, last_idx, iptr_step, rd_idx;
  logic [IW-1:0] rd_data;
  logic [AW:0]   ring_count;
  logic          ring_full, ring_empty;
  logic          legal, push, pop;

  assign legal = is_legal_arith(wr_instr);
  assign push  = wr_en && legal && !ring_full;
  assign pop   = (state_q == S_PRESENT) && rd_ready && !loop_q;

  instr_ring #(
    .DEPTH (DEPTH),
    .W     (IW)
  ) u_ring (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (wr_instr),
    .pop_i       (pop),
    .rd_idx_i    (rd_idx),
    .rd_data_o   (rd_data),
    .head_o      (head),
    .tail_o      (tail),
    .count_o     (ring_count),
    .full_o      (ring_full),
    .empty_o     (ring_empty)
  );

  // Replay wraps against the pre-edge tail, so a same-edge write joins the next lap.
  assign last_idx  = tail - 1'b1;
  assign iptr_step = (iptr_q == last_idx) ? head : iptr_q + 1'b1;

  // One read port: the address selects whichever entry the next presentation needs.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    iptr_d  = iptr_q;
    loop_d  = loop_q;
    rd_idx  = head;
    case (state_q)
      S_IDLE: begin
        if (run && !ring_empty) begin
          state_d = S_PRESENT;
          loop_d  = loop;
          iptr_d  = head;
          instr_d = rd_data;
        end
      end
      S_PRESENT: begin
        if (rd_ready) begin
          if (loop_q) begin
            rd_idx = iptr_step;
            iptr_d = iptr_step;
            if (run) instr_d = rd_data;
            else     state_d = S_IDLE;
          end else if (run && (ring_count > (AW+1)'(1))) begin
            rd_idx  = head + 1'b1;
            iptr_d  = head + 1'b1;
            instr_d = rd_data;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      iptr_q   <= '0;
      loop_q   <= 1'b0;
      reject_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      iptr_q   <= iptr_d;
      loop_q   <= loop_d;
      reject_q <= wr_en && !push;
      if (wr_en && !legal) err_q <= 1'b1;
      else if (clr_err)    err_q <= 1'b0;
    end
  end

  assign wr_full     = ring_full;
  assign wr_reject   = reject_q;
  assign instr_valid = (state_q == S_PRESENT);
  assign instr_out   = instr_q;
  assign count       = ring_count;
  assign empty       = ring_empty;
  assign err_sticky  = err_q;

endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed and randomized bench for instr_issue_queue against a queue-based reference model.
module tb_instr_issue_queue;

  localparam int unsigned DEPTH = 8;

  logic       clock = 1'b0;
  logic       reset, wr_en, run, loop, rd_ready, clr_err;
  logic [7:0] wr_instr;
  logic       wr_full, wr_reject, instr_valid, empty, err_sticky;
  logic [7:0] instr_out;
  logic [3:0] count;

  always #5 clock = ~clock;

  instr_issue_queue #(
    .DEPTH (DEPTH),
    .IW    (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_instr    (wr_instr),
    .wr_full     (wr_full),
    .wr_reject   (wr_reject),
    .run         (run),
    .loop        (loop),
    .rd_ready    (rd_ready),
    .instr_valid (instr_valid),
    .instr_out   (instr_out),
    .count       (count),
    .empty       (empty),
    .err_sticky  (err_sticky),
    .clr_err     (clr_err)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] mq[$];
  bit         m_valid, m_loop, m_reject, m_err;
  int         m_pos;
  logic [7:0] m_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_legal(input logic [7:0] w);
    logic [2:0] opc;
    opc = w[6:4];
    return (w[7] == 1'b0) && (opc == 3'd1 || opc == 3'd3);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_valid = 0; m_loop = 0; m_reject = 0; m_err = 0; m_pos = 0; m_out = 8'h00;
  endtask

  // One clock edge of the reference behaviour, using pre-edge model state.
  task automatic model_edge();
    bit acc;
    int sz;
    sz  = mq.size();
    acc = wr_en && m_legal(wr_instr) && (sz != DEPTH);
    m_reject = wr_en && !acc;
    if (wr_en && !m_legal(wr_instr)) m_err = 1;
    else if (clr_err)                m_err = 0;
    if (!m_valid) begin
      if (run && sz > 0) begin
        m_valid = 1; m_loop = loop; m_pos = 0; m_out = mq[0];
      end
    end else if (rd_ready) begin
      if (m_loop) begin
        m_pos = (m_pos + 1) % sz;
        if (run) m_out = mq[m_pos];
        else     m_valid = 0;
      end else begin
        void'(mq.pop_front());
        if (run && sz > 1) m_out = mq[0];
        else               m_valid = 0;
      end
    end
    if (acc) mq.push_back(wr_instr);
  endtask

  task automatic check_all();
    chk("instr_valid", instr_valid, m_valid);
    chk("instr_out",   instr_out,   m_out);
    chk("count",       count,       mq.size());
    chk("empty",       empty,       mq.size() == 0);
    chk("wr_full",     wr_full,     mq.size() == DEPTH);
    chk("wr_reject",   wr_reject,   m_reject);
    chk("err_sticky",  err_sticky,  m_err);
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
    model_edge();
    check_all();
  endtask

  task automatic wr(input logic [7:0] w);
    wr_en = 1; wr_instr = w;
    cycle();
    wr_en = 0;
  endtask

  logic [7:0] seq4 [7];

  initial begin
    reset = 1; wr_en = 0; wr_instr = 8'h00; run = 0; loop = 0; rd_ready = 0; clr_err = 0;
    model_reset();
    #12;
    check_all();
    chk("rst_out", instr_out, 8'h00);
    reset = 0;

    // 1: single write, issue on the following edge, handshake empties
    run = 1;
    wr(8'h14);
    chk("t1_pre_valid", instr_valid, 1'b0);
    cycle();
    chk("t1_valid", instr_valid, 1'b1);
    chk("t1_out", instr_out, 8'h14);
    rd_ready = 1;
    cycle();
    chk("t1_empty", empty, 1'b1);
    chk("t1_idle", instr_valid, 1'b0);
    rd_ready = 0;

    // 2: illegal writes
    wr(8'h20);
    chk("t2_rej_a", wr_reject, 1'b1);
    wr(8'h94);
    chk("t2_rej_b", wr_reject, 1'b1);
    chk("t2_err", err_sticky, 1'b1);
    chk("t2_count", count, 4'd0);
    clr_err = 1; cycle(); clr_err = 0;
    chk("t2_clr", err_sticky, 1'b0);

    // 3: fill, overflow, drain back-to-back
    run = 0;
    for (int i = 0; i < 8; i++) wr(8'h10 + 8'(i));
    chk("t3_full", wr_full, 1'b1);
    wr(8'h35);
    chk("t3_rej", wr_reject, 1'b1);
    chk("t3_count", count, 4'd8);
    run = 1; rd_ready = 1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("t3_drain_valid", instr_valid, 1'b1);
      chk("t3_drain_out", instr_out, 8'h10 + 8'(k));
    end
    cycle();
    chk("t3_empty", empty, 1'b1);
    rd_ready = 0; run = 0;

    // 4: loop replay
    wr(8'h14); wr(8'h34); wr(8'h35);
    seq4 = '{8'h14, 8'h34, 8'h35, 8'h14, 8'h34, 8'h35, 8'h14};
    loop = 1; run = 1;
    cycle();
    rd_ready = 1;
    for (int h = 0; h < 7; h++) begin
      chk("t4_seq", instr_out, seq4[h]);
      cycle();
    end
    chk("t4_count", count, 4'd3);
    run = 0;
    cycle();
    chk("t4_exit", instr_valid, 1'b0);
    loop = 0; run = 1;
    for (int i = 0; i < 5; i++) cycle();
    chk("t4_drained", empty, 1'b1);
    rd_ready = 0;

    // 5: dropping run holds the presentation until handshake
    wr(8'h34);
    cycle();
    run = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t5_hold_valid", instr_valid, 1'b1);
      chk("t5_hold_out", instr_out, 8'h34);
    end
    rd_ready = 1;
    cycle();
    chk("t5_idle", instr_valid, 1'b0);
    rd_ready = 0;

    // 6: async reset mid-presentation
    for (int i = 0; i < 5; i++) wr(8'h30 + 8'(i));
    run = 1;
    cycle();
    chk("t6_pre_valid", instr_valid, 1'b1);
    chk("t6_pre_count", count, 4'd5);
    #2 reset = 1;
    #1;
    chk("t6_valid", instr_valid, 1'b0);
    chk("t6_count", count, 4'd0);
    model_reset();
    check_all();
    run = 0;
    @(posedge clock);
    #3 reset = 0;

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      run      = ($urandom % 8) != 0;
      loop     = ($urandom % 4) == 0;
      rd_ready = ($urandom % 3) != 0;
      wr_en    = $urandom % 2;
      clr_err  = ($urandom % 8) == 0;
      if (($urandom % 4) == 0) wr_instr = 8'($urandom);
      else wr_instr = {1'b0, (($urandom % 2) != 0) ? 3'b001 : 3'b011, 4'($urandom)};
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
